// File: rtl/conv_kxk_mac_if.sv
// Handshake bundle for conv_kxk_mac: window/weight/bias input channel and result output channel.
interface conv_kxk_mac_if #(
  parameter int K      = 5,
  parameter int DATA_W = 9,
  parameter int BIAS_W = 9,
  parameter int ACC_W  = 24
);
  logic                     in_valid;
  logic                     in_ready;
  logic [K*K*DATA_W-1:0]    x_win;
  logic [K*K*DATA_W-1:0]    w_win;
  logic signed [BIAS_W-1:0] bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_row_last;

  modport master (
    output in_valid, x_win, w_win, bias, out_ready,
    input  in_ready, out_valid, out_data, out_row_last
  );

  modport slave (
    input  in_valid, x_win, w_win, bias, out_ready,
    output in_ready, out_valid, out_data, out_row_last
  );
endinterface

// File: rtl/conv_kxk_mac.sv
// KxK signed convolution window MAC: K row lanes in parallel, one column per cycle, bias add and
// row-padding window drop. Define CONV_KXK_RELU_EN to clamp negative totals to zero.
module conv_kxk_mac #(
  parameter int K         = 5,
  parameter int DATA_W    = 9,
  parameter int BIAS_W    = 9,
  parameter int ACC_W     = 24,
  parameter int ROW_WIN   = 32,
  parameter int VALID_WIN = 28
) (
  input  logic          clk,
  input  logic          rst,
  conv_kxk_mac_if.slave bus
);
  localparam int MIN_ACC_W = 2 * DATA_W + $clog2(K * K) + 1;
  localparam int COL_W     = $clog2(K);
  localparam int CNT_W     = $clog2(ROW_WIN + 1);
  localparam int ROW_BITS  = K * DATA_W;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(K - 1);
  localparam logic [CNT_W-1:0] CNT_WRAP      = CNT_W'(ROW_WIN - 1);
  localparam logic [CNT_W-1:0] CNT_EMIT      = CNT_W'(VALID_WIN);
  localparam logic [CNT_W-1:0] CNT_LAST_EMIT = CNT_W'(VALID_WIN - 1);

  generate
    if (K < 2 || K > 8) begin : g_bad_k
      $error("conv_kxk_mac: K must be within 2..8");
    end
    if (ACC_W < MIN_ACC_W) begin : g_bad_acc_w
      $error("conv_kxk_mac: ACC_W too narrow for exact accumulation");
    end
    if (VALID_WIN < 1 || VALID_WIN > ROW_WIN) begin : g_bad_valid_win
      $error("conv_kxk_mac: VALID_WIN must be within 1..ROW_WIN");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MAC, SUM, OUT} state_t;

  state_t                   state;
  state_t                   next_state;
  logic signed [DATA_W-1:0] x_pix [K][K];
  logic signed [DATA_W-1:0] w_pix [K][K];
  logic signed [BIAS_W-1:0] bias_q;
  logic signed [ACC_W-1:0]  acc   [K];
  logic signed [ACC_W-1:0]  prod  [K];
  logic signed [ACC_W-1:0]  total;
  logic signed [ACC_W-1:0]  result;
  logic signed [ACC_W-1:0]  out_data_q;
  logic [COL_W-1:0]         col;
  logic [CNT_W-1:0]         win_cnt;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     out_row_last_q;
  logic                     accept;
  logic                     emit;

  // in_ready_q is registered, so it is only ever high while the FSM sits in IDLE
  assign accept = bus.in_valid && in_ready_q;
  assign emit   = (win_cnt < CNT_EMIT);

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_row_last = out_row_last_q;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      prod[r] = ACC_W'(x_pix[r][col]) * ACC_W'(w_pix[r][col]);
    end
  end

  always_comb begin
    total = ACC_W'(bias_q);
    for (int r = 0; r < K; r++) begin
      total = total + acc[r];
    end
`ifdef CONV_KXK_RELU_EN
    result = total[ACC_W-1] ? '0 : total;
`else
    result = total;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = MAC;
      MAC:     if (col == COL_LAST) next_state = SUM;
      SUM:     next_state = emit ? OUT : IDLE;
      OUT:     if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Window capture, lane accumulation, row-position counting and the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_row_last_q <= 1'b0;
      out_data_q     <= '0;
      win_cnt        <= '0;
      col            <= '0;
      for (int r = 0; r < K; r++) begin
        acc[r] <= '0;
      end
    end else begin
      in_ready_q <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            for (int r = 0; r < K; r++) begin
              for (int c = 0; c < K; c++) begin
                x_pix[r][c] <= bus.x_win[(K - r) * ROW_BITS - c * DATA_W - 1 -: DATA_W];
                w_pix[r][c] <= bus.w_win[(K - r) * ROW_BITS - c * DATA_W - 1 -: DATA_W];
              end
              acc[r] <= '0;
            end
            bias_q <= bus.bias;
            col    <= '0;
          end
        end
        MAC: begin
          for (int r = 0; r < K; r++) begin
            acc[r] <= acc[r] + prod[r];
          end
          col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
        end
        SUM: begin
          win_cnt <= (win_cnt == CNT_WRAP) ? '0 : win_cnt + CNT_W'(1);
          if (emit) begin
            out_data_q     <= result;
            out_valid_q    <= 1'b1;
            out_row_last_q <= (win_cnt == CNT_LAST_EMIT);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q    <= 1'b0;
            out_row_last_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_kxk_mac.sv
// Scoreboard bench for conv_kxk_mac: default 5x5 instance plus a small K=3 instance with random windows.
module tb_conv_kxk_mac;
  localparam int K   = 5,  DW  = 9, BW  = 9, AW  = 24, RW  = 32, VW  = 28;
  localparam int K3  = 3,  DW3 = 8, BW3 = 8, AW3 = 21, RW3 = 4,  VW3 = 2;
  localparam int WW  = K * K * DW;
  localparam int WW3 = K3 * K3 * DW3;
  localparam int TIMEOUT = 50;

  typedef struct {
    longint data;
    logic   last;
  } exp_t;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst3 = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  conv_kxk_mac_if #(.K(K), .DATA_W(DW), .BIAS_W(BW), .ACC_W(AW)) bus ();
  conv_kxk_mac_if #(.K(K3), .DATA_W(DW3), .BIAS_W(BW3), .ACC_W(AW3)) bus3 ();

  conv_kxk_mac #(.K(K), .DATA_W(DW), .BIAS_W(BW), .ACC_W(AW), .ROW_WIN(RW), .VALID_WIN(VW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Smallest accumulator width the width check accepts for K=3, DATA_W=8
  conv_kxk_mac #(.K(K3), .DATA_W(DW3), .BIAS_W(BW3), .ACC_W(AW3), .ROW_WIN(RW3), .VALID_WIN(VW3)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3)
  );

  function automatic longint relu(input longint v);
`ifdef CONV_KXK_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [WW-1:0] fill(input int v);
    logic [WW-1:0] p;
    for (int i = 0; i < K * K; i++) p[i*DW +: DW] = DW'(v);
    return p;
  endfunction

  function automatic logic [WW-1:0] corner(input int v);
    logic [WW-1:0] p;
    p = '0;
    p[WW-1 -: DW] = DW'(v);
    return p;
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.x_win     = '0;
    bus.w_win     = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
  endtask

  // Presents a window and returns one time unit after the edge that accepted it
  task automatic send(input logic [WW-1:0] x, input logic [WW-1:0] w, input int b, output logic ok);
    int n = 0;
    bus.x_win    = x;
    bus.w_win    = w;
    bus.bias     = BW'(b);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x_win    = ~x;
    bus.w_win    = ~w;
    bus.bias     = ~bus.bias;
  endtask

  // Waits for a result or for the block to return to idle without one
  task automatic collect(output logic got, output longint data, output logic last, output int lat);
    logic done = 1'b0;
    got = 1'b0; data = 0; last = 1'b0; lat = 0;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) begin
        got  = 1'b1;
        data = longint'(bus.out_data);
        last = bus.out_row_last;
        done = 1'b1;
      end else if (bus.in_ready) begin
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    bus.x_win    = fill(3);
    bus.w_win    = fill(3);
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_row_last} !== 3'b000 || bus.out_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: in_ready=%b out_valid=%b row_last=%b out_data=%0d, expected 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_row_last, bus.out_data);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic_latency();
    logic ok, got, last;
    longint data;
    int lat;
    exp_t e;
    do_reset();
    sb.push_back('{relu(longint'(K * K) + 0), 1'b0});
    send(fill(1), fill(1), 0, ok);
    collect(got, data, last, lat);
    n_tests++;
    if (!ok || !got || sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL basic_output: accepted=%b got=%b, expected 1 1", ok, got);
    end else begin
      e = sb.pop_front();
      if (data !== e.data || last !== e.last || lat != K + 1) begin
        n_fail++;
        $display("[TB] FAIL basic_result: data=%0d last=%b latency=%0d, expected %0d %b %0d",
                 data, last, lat, e.data, e.last, K + 1);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_ready_after_handshake: in_ready=%b out_valid=%b, expected 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_signed_extremes();
    int xs[2] = '{-256, -256};
    int ws[2] = '{-256, 255};
    logic ok, got, last;
    longint data;
    int lat;
    exp_t e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{relu(longint'(K * K) * xs[i] * ws[i] - 256), 1'b0});
      send(fill(xs[i]), fill(ws[i]), -256, ok);
      collect(got, data, last, lat);
      n_tests++;
      if (!got || sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL extreme_%0d_output: got=%b accepted=%b, expected 1 1", i, got, ok);
      end else begin
        e = sb.pop_front();
        if (data !== e.data || last !== e.last) begin
          n_fail++;
          $display("[TB] FAIL extreme_%0d_result: data=%0d last=%b, expected %0d %b", i, data, last, e.data, e.last);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok, got, last;
    longint data;
    int lat;
    exp_t e;
    do_reset();
    bus.out_ready = 1'b0;
    sb.push_back('{relu(longint'(K * K) * 2 * 3 + 5), 1'b0});
    sb.push_back('{relu(longint'(K * K) * (-1) * 4 - 7), 1'b0});
    send(fill(2), fill(3), 5, ok);
    lat = 0;
    while (!bus.out_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    bus.x_win    = fill(-1);
    bus.w_win    = fill(4);
    bus.bias     = BW'(-7);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || longint'(bus.out_data) !== e.data || bus.out_row_last !== 1'b0 ||
          bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_hold_%0d: valid=%b data=%0d last=%b in_ready=%b, expected 1 %0d 0 0",
                 c, bus.out_valid, bus.out_data, bus.out_row_last, bus.in_ready, e.data);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_accept_next: in_ready=%b, expected 0", bus.in_ready);
    end
    collect(got, data, last, lat);
    n_tests++;
    if (!got || sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL bp_second_output: got=%b, expected 1", got);
    end else begin
      e = sb.pop_front();
      if (data !== e.data || lat != K + 1) begin
        n_fail++;
        $display("[TB] FAIL bp_second_result: data=%0d latency=%0d, expected %0d %0d", data, lat, e.data, K + 1);
      end
    end
  endtask

  task automatic test_row_padding();
    logic ok, got, last, want;
    longint data;
    int lat, emitted;
    exp_t e;
    do_reset();
    emitted = 0;
    for (int i = 0; i < 2 * RW; i++) begin
      want = ((i % RW) < VW);
      if (want) sb.push_back('{relu(1 + longint'(i)), (i % RW) == VW - 1});
      send(corner(1), corner(1), i, ok);
      collect(got, data, last, lat);
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL row_emit_%0d: output=%b, expected %b (latency %0d)", i, got, want, lat);
      end else if (got) begin
        emitted++;
        e = sb.pop_front();
        if (data !== e.data || last !== e.last) begin
          n_fail++;
          $display("[TB] FAIL row_result_%0d: data=%0d last=%b, expected %0d %b", i, data, last, e.data, e.last);
        end
      end
    end
    n_tests++;
    if (emitted != 2 * VW || sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL row_count: outputs=%0d pending=%0d, expected %0d 0", emitted, sb.size(), 2 * VW);
    end
  endtask

  task automatic test_reset_mid_op();
    logic ok, got, last, want;
    longint data;
    int lat;
    exp_t e;
    do_reset();
    send(fill(1), fill(1), 0, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_in_reset: out_valid=%b in_ready=%b, expected 0 0", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_ready: in_ready=%b, expected 1", bus.in_ready);
    end
    for (int i = 0; i <= VW; i++) begin
      want = (i < VW);
      if (want) sb.push_back('{relu(1 + longint'(i)), i == VW - 1});
      send(corner(1), corner(1), i, ok);
      collect(got, data, last, lat);
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL midrst_emit_%0d: output=%b, expected %b", i, got, want);
      end else if (got) begin
        e = sb.pop_front();
        if (data !== e.data || last !== e.last) begin
          n_fail++;
          $display("[TB] FAIL midrst_result_%0d: data=%0d last=%b, expected %0d %b", i, data, last, e.data, e.last);
        end
      end
    end
  endtask

  task automatic test_param_sweep();
    int xv [K3][K3];
    int wv [K3][K3];
    int b, n, lat;
    longint m;
    logic [WW3-1:0] xp, wp;
    logic want, got, done;
    exp_t e;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    for (int j = 0; j < 3 * RW3; j++) begin
      b = int'($urandom_range(255)) - 128;
      m = b;
      for (int r = 0; r < K3; r++) begin
        for (int c = 0; c < K3; c++) begin
          xv[r][c] = int'($urandom_range(255)) - 128;
          wv[r][c] = int'($urandom_range(255)) - 128;
          xp[(K3 - r) * K3 * DW3 - c * DW3 - 1 -: DW3] = DW3'(xv[r][c]);
          wp[(K3 - r) * K3 * DW3 - c * DW3 - 1 -: DW3] = DW3'(wv[r][c]);
          m += longint'(xv[r][c]) * wv[r][c];
        end
      end
      want = ((j % RW3) < VW3);
      if (want) sb.push_back('{relu(m), (j % RW3) == VW3 - 1});
      bus3.x_win = xp; bus3.w_win = wp; bus3.bias = BW3'(b); bus3.in_valid = 1'b1;
      n = 0;
      while (!bus3.in_ready && n < TIMEOUT) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      bus3.in_valid = 1'b0;
      bus3.x_win = ~xp;
      lat = 0; got = 1'b0; done = 1'b0;
      while (!done && lat < TIMEOUT) begin
        @(posedge clk); #1;
        lat++;
        if (bus3.out_valid) begin got = 1'b1; done = 1'b1; end
        else if (bus3.in_ready) done = 1'b1;
      end
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL sweep_emit_%0d: output=%b, expected %b", j, got, want);
      end else if (got) begin
        e = sb.pop_front();
        if (longint'(bus3.out_data) !== e.data || bus3.out_row_last !== e.last || lat != K3 + 1) begin
          n_fail++;
          $display("[TB] FAIL sweep_result_%0d: data=%0d last=%b latency=%0d, expected %0d %b %0d",
                   j, bus3.out_data, bus3.out_row_last, lat, e.data, e.last, K3 + 1);
        end
      end
    end
  endtask

  initial begin
    bus3.in_valid  = 1'b0;
    bus3.x_win     = '0;
    bus3.w_win     = '0;
    bus3.bias      = '0;
    bus3.out_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_latency();
    test_signed_extremes();
    test_backpressure();
    test_row_padding();
    test_reset_mid_op();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
